// File: rtl/uart_bitvec_loader_if.sv
// uart_bitvec_loader_if: groups the loader's control, UART read-side and result
// signals. The "slave" modport is the loader itself. The "master" modport is the
// surrounding logic, which supplies start and the FIFO view and consumes results.
interface uart_bitvec_loader_if #(
  parameter int NBITS = 66,
  parameter int CNT_W = 11
);
  logic             start;
  logic             rx_empty;
  logic [7:0]       rx_data;
  logic             rd_uart;
  logic [NBITS-1:0] vec;
  logic [CNT_W-1:0] bit_count;
  logic             busy;
  logic             done;
  logic             done_tick;
  logic             err;
  logic             wr_uart;
  logic [7:0]       wr_data;

  modport master (
    output start, rx_empty, rx_data,
    input  rd_uart, vec, bit_count, busy, done, done_tick, err, wr_uart, wr_data
  );

  modport slave (
    input  start, rx_empty, rx_data,
    output rd_uart, vec, bit_count, busy, done, done_tick, err, wr_uart, wr_data
  );
endinterface

// File: rtl/uart_bitvec_loader.sv
// uart_bitvec_loader: pulls ASCII '0'/'1' characters from a first-word-fall-through
// UART receive FIFO and packs them into an NBITS-wide vector.
// Each character takes three cycles: LOAD decodes it, POP strobes rd_uart and
// applies the result, and SETTLE waits for the FIFO outputs to refresh.
// CR, LF and space are skipped. Any other character is discarded and sets the
// sticky err flag.
// Optional echo of received characters is enabled by defining UART_BITVEC_ECHO_EN.
module uart_bitvec_loader #(
  parameter int NBITS     = 66,
  parameter int CNT_W     = 11,
  parameter int LSB_FIRST = 1
) (
  input  logic               CLK,
  input  logic               reset,
  uart_bitvec_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_POP    = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    K_BIT  = 2'd0,
    K_SKIP = 2'd1,
    K_BAD  = 2'd2
  } kind_t;

  localparam logic [CNT_W-1:0] L_NBITS   = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
  localparam logic [NBITS-1:0] L_VEC_ONE = NBITS'(1);

  // Classify one received byte as a data bit, a skipped separator or garbage.
  function automatic kind_t f_decode(input logic [7:0] b);
    kind_t k;
    case (b)
      8'h30, 8'h31:        k = K_BIT;
      8'h0D, 8'h0A, 8'h20: k = K_SKIP;
      default:             k = K_BAD;
    endcase
    return k;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NBITS-1:0] r_vec;
  logic [NBITS-1:0] w_vec_nxt;
  logic [CNT_W-1:0] r_bit_count;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rd_uart;
  logic             w_rd_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_done_tick;
  logic             w_tick_nxt;
  logic             r_err;
  logic             w_err_nxt;
  kind_t            r_dec_kind;
  kind_t            w_kind_nxt;
  logic             r_dec_bit;
  logic             w_dbit_nxt;

  // State register; reset drops straight into LOAD so loading starts immediately.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-value logic; start overrides everything except reset.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_bit_count;
    w_rd_nxt    = 1'b0;
    w_done_nxt  = r_done;
    w_tick_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_kind_nxt  = r_dec_kind;
    w_dbit_nxt  = r_dec_bit;
    if (bus.start) begin
      // A decode latched for POP is dropped here; a pop already on the bus completes.
      w_state_nxt = S_LOAD;
      w_vec_nxt   = '0;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_LOAD: begin
          if (!bus.rx_empty) begin
            w_kind_nxt  = f_decode(bus.rx_data);
            w_dbit_nxt  = bus.rx_data[0];
            w_rd_nxt    = 1'b1;
            w_state_nxt = S_POP;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
        S_POP: begin
          w_state_nxt = S_SETTLE;
          case (r_dec_kind)
            K_BIT: begin
              if (r_bit_count < L_NBITS) begin
                if (LSB_FIRST != 0) begin
                  w_vec_nxt = (r_vec & ~(L_VEC_ONE << r_bit_count))
                            | (NBITS'(r_dec_bit) << r_bit_count);
                end else begin
                  w_vec_nxt = {r_vec[NBITS-2:0], r_dec_bit};
                end
                w_cnt_nxt = r_bit_count + L_CNT_ONE;
              end else begin
                w_cnt_nxt = r_bit_count;
              end
            end
            K_SKIP: begin
              w_cnt_nxt = r_bit_count;
            end
            K_BAD: begin
              w_err_nxt = 1'b1;
            end
            default: begin
              w_err_nxt = 1'b1;
            end
          endcase
        end
        S_SETTLE: begin
          if (r_bit_count == L_NBITS) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_tick_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
        S_DONE: begin
          // Remaining FIFO bytes are left in place for the next load.
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
        default: begin
          w_state_nxt = S_LOAD;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_POP) ||
                 (w_state_nxt == S_SETTLE);
  end

  // Registered outputs and the latched decode result.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_vec       <= '0;
      r_bit_count <= '0;
      r_rd_uart   <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_done_tick <= 1'b0;
      r_err       <= 1'b0;
      r_dec_kind  <= K_SKIP;
      r_dec_bit   <= 1'b0;
    end else begin
      r_vec       <= w_vec_nxt;
      r_bit_count <= w_cnt_nxt;
      r_rd_uart   <= w_rd_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_done_tick <= w_tick_nxt;
      r_err       <= w_err_nxt;
      r_dec_kind  <= w_kind_nxt;
      r_dec_bit   <= w_dbit_nxt;
    end
  end

  assign bus.vec       = r_vec;
  assign bus.bit_count = r_bit_count;
  assign bus.rd_uart   = r_rd_uart;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.done_tick = r_done_tick;
  assign bus.err       = r_err;

`ifdef UART_BITVEC_ECHO_EN
  logic       r_wr_uart;
  logic       w_wr_nxt;
  logic [7:0] r_wr_data;
  logic [7:0] w_wr_data_nxt;

  // Echo strobe timed to coincide with POP, plus a newline alongside done_tick.
  always_comb begin
    w_wr_nxt      = 1'b0;
    w_wr_data_nxt = 8'h00;
    if (bus.start) begin
      w_wr_nxt      = 1'b0;
      w_wr_data_nxt = 8'h00;
    end else if ((r_state == S_LOAD) && !bus.rx_empty) begin
      w_wr_nxt      = 1'b1;
      w_wr_data_nxt = (f_decode(bus.rx_data) == K_BAD) ? 8'h3F : bus.rx_data;
    end else if ((r_state == S_SETTLE) && (r_bit_count == L_NBITS)) begin
      w_wr_nxt      = 1'b1;
      w_wr_data_nxt = 8'h0A;
    end else begin
      w_wr_nxt      = 1'b0;
      w_wr_data_nxt = 8'h00;
    end
  end

  // Echo output registers; the transmit FIFO full flag is deliberately ignored.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wr_uart <= 1'b0;
      r_wr_data <= 8'h00;
    end else begin
      r_wr_uart <= w_wr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  assign bus.wr_uart = r_wr_uart;
  assign bus.wr_data = r_wr_data;
`else
  assign bus.wr_uart = 1'b0;
  assign bus.wr_data = 8'h00;
`endif

endmodule
